// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol controller: Moore FSM sequencing address check, ACK/NACK, byte TX/RX and FIFO handshakes.
// Latency: outputs follow the registered state, one cycle after the triggering bus pulse.
// Optional macro I2C_SLAVE_CTRL_GEN_CALL_EN also ACKs the general call address 8'h00 (write only).
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h78
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       byte_received,
  input  logic       check_ack,
  input  logic       ack_done,
  input  logic       sda_in,
  input  logic [7:0] rx_data,
  input  logic       tx_empty,
  input  logic       rx_full,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       load_data,
  output logic       tx_read,
  output logic       rx_write,
  output logic [1:0] sda_mode,
  output logic       tx_underflow
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR_RX   = 4'd1;
  localparam logic [3:0] S_ADDR_CHK  = 4'd2;
  localparam logic [3:0] S_ACK_ADDR  = 4'd3;
  localparam logic [3:0] S_NACK      = 4'd4;
  localparam logic [3:0] S_LOAD      = 4'd5;
  localparam logic [3:0] S_TX_BYTE   = 4'd6;
  localparam logic [3:0] S_WAIT_MACK = 4'd7;
  localparam logic [3:0] S_DATA_RX   = 4'd8;
  localparam logic [3:0] S_ACK_DATA  = 4'd9;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       r_rw;
  logic       r_mack;
  logic       r_mack_seen;
  logic       r_drop;
  logic       r_rx_write;
  logic       r_tx_read;
  logic       r_underflow;
  logic       w_own_addr;
  logic       w_gen_call;
  logic       w_addr_hit;
  logic       w_mack;

  // Address match; the general call is only accepted when the feature macro is defined.
  always_comb begin
    w_own_addr = (rx_data[7:1] == SLAVE_ADDR);
`ifdef I2C_SLAVE_CTRL_GEN_CALL_EN
    w_gen_call = (rx_data == 8'h00);
`else
    w_gen_call = 1'b0;
`endif
    w_addr_hit = w_own_addr || w_gen_call;
    // If ack_done lands in the same cycle as the first check_ack, use the live SDA value.
    w_mack     = (check_ack && !r_mack_seen) ? sda_in : r_mack;
  end

  // Next-state logic; START/STOP overrides are applied last so they win over everything.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start_found) w_next = S_ADDR_RX;
      S_ADDR_RX:   if (byte_received) w_next = S_ADDR_CHK;
      S_ADDR_CHK:  w_next = w_addr_hit ? S_ACK_ADDR : S_NACK;
      S_ACK_ADDR:  if (ack_done) w_next = r_rw ? S_LOAD : S_DATA_RX;
      S_NACK:      if (ack_done) w_next = S_IDLE;
      S_LOAD:      w_next = S_TX_BYTE;
      S_TX_BYTE:   if (byte_received) w_next = S_WAIT_MACK;
      S_WAIT_MACK: if (ack_done) w_next = w_mack ? S_IDLE : S_LOAD;
      S_DATA_RX:   if (byte_received) w_next = S_ACK_DATA;
      S_ACK_DATA:  if (ack_done) w_next = S_DATA_RX;
      default:     w_next = S_IDLE;
    endcase
    if (start_found)     w_next = S_ADDR_RX;
    else if (stop_found) w_next = S_IDLE;
  end

  // State register plus the flags the output decode depends on.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_rw        <= 1'b0;
      r_mack      <= 1'b1;
      r_mack_seen <= 1'b0;
      r_drop      <= 1'b0;
      r_rx_write  <= 1'b0;
      r_tx_read   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_next;
      // General call matches only via w_gen_call, so it always latches as a write.
      if (r_state == S_ADDR_CHK && w_addr_hit)
        r_rw <= w_own_addr ? rx_data[0] : 1'b0;
      // Master ACK is taken from the first check_ack cycle only; re-armed outside WAIT_MACK.
      if (r_state == S_WAIT_MACK) begin
        if (check_ack && !r_mack_seen) begin
          r_mack      <= sda_in;
          r_mack_seen <= 1'b1;
        end
      end else begin
        r_mack_seen <= 1'b0;
      end
      // FIFO status is sampled on the transition; it can only become safer before the flag is used
      // because this block is the only one popping tx / pushing rx.
      if (r_state == S_DATA_RX && w_next == S_ACK_DATA)
        r_drop <= rx_full;
      r_rx_write  <= (r_state == S_DATA_RX) && (w_next == S_ACK_DATA) && !rx_full;
      r_tx_read   <= (w_next == S_LOAD) && !tx_empty;
      // The shift register loads 8'hFF when it sees tx_underflow alongside load_data.
      r_underflow <= (w_next == S_LOAD) && tx_empty;
    end
  end

  // Moore output decode from registered state and flags only.
  always_comb begin
    rx_enable    = (r_state == S_ADDR_RX) || (r_state == S_DATA_RX);
    tx_enable    = (r_state == S_TX_BYTE);
    load_data    = (r_state == S_LOAD);
    tx_read      = r_tx_read;
    rx_write     = r_rx_write;
    tx_underflow = r_underflow;
    case (r_state)
      S_ACK_ADDR: sda_mode = 2'b01;
      S_NACK:     sda_mode = 2'b10;
      S_TX_BYTE:  sda_mode = 2'b11;
      S_ACK_DATA: sda_mode = r_drop ? 2'b10 : 2'b01;
      default:    sda_mode = 2'b00;
    endcase
  end

endmodule
